// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared constants, state type and one-hot helper for the 4-way dispatcher
package dispatch_pkg;
  localparam int N_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, HOLD} disp_state_t;
  function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] s);
    return {{(N_CH-1){1'b0}}, 1'b1} << s;
  endfunction
endpackage

// File: rtl/dmux4_dispatcher_rr_pick4.sv
// rr_pick4: rotating-priority picker, first ready channel at or after base, base when none ready
module rr_pick4 (
  input  logic [1:0] base,
  input  logic [3:0] req,
  output logic [1:0] pick
);
  logic [3:0] rot;
  logic [1:0] off;
  // rotate so base lands at bit 0, then take the lowest set bit as the offset from base
  always_comb begin
    rot = 4'({req, req} >> base);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : rot[3] ? 2'd3 : 2'd0;
    pick = base + off;
  end
endmodule

// File: rtl/dmux4_dispatcher.sv
// dmux4_dispatcher: round-robin one-word dispatcher to four channels; DISPATCH_STATS_EN adds per-channel counters
module dmux4_dispatcher
  import dispatch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
  output logic             busy
`ifdef DISPATCH_STATS_EN
  ,
  output logic [4*CNT_W-1:0] cnt_flat
`endif
);
  disp_state_t state, state_nx;
  logic [1:0] ptr, base, pick;
  logic [WIDTH-1:0] hold;
  logic accept, capture;
  assign accept = (state == HOLD) && out_ready[sel];
  assign in_ready = (state == IDLE) || accept;
  assign capture = in_valid && in_ready;
  assign base = (state == IDLE) ? ptr : sel + 2'd1;
  assign out_valid = (state == HOLD) ? onehot4(sel) : 4'b0000;
  assign busy = (state == HOLD);
  assign out_data = hold;
  rr_pick4 u_pick (
    .base(base),
    .req (out_ready),
    .pick(pick)
  );
  // a capture always (re)fills the buffer; an accept without capture empties it
  always_comb state_nx = capture ? HOLD : accept ? IDLE : state;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // destination and word are latched at capture and frozen until accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= 2'd0;
      sel <= 2'd0;
      hold <= '0;
    end else begin
      if (accept) ptr <= sel + 2'd1;
      if (capture) begin
        hold <= in_data;
        sel <= pick;
      end
    end
`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt [4];
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    // saturating count of words accepted on channel k
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt[k] <= '0;
      else if (accept && sel == 2'(k) && cnt[k] != {CNT_W{1'b1}}) cnt[k] <= cnt[k] + 1'b1;
    assign cnt_flat[k*CNT_W +: CNT_W] = cnt[k];
  end
`endif
endmodule

// File: tb/tb_dmux4_dispatcher.sv
// tb_dmux4_dispatcher: directed scenarios plus random traffic checked against a queue-level model
module tb_dmux4_dispatcher;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, busy;
  logic [WIDTH-1:0] in_data = 0, out_data;
  logic [3:0] out_valid, out_ready = 0;
  logic [1:0] sel;
`ifdef DISPATCH_STATS_EN
  logic [4*CNT_W-1:0] cnt_flat;
`endif
  int n_chk = 0, n_pass = 0;

  dmux4_dispatcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .sel(sel), .busy(busy)
`ifdef DISPATCH_STATS_EN
    , .cnt_flat(cnt_flat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // model: a single-slot offer with a destination; ptr remembers where round-robin resumes
  bit m_full;
  int m_sel, m_ptr, m_word;
  int m_cnt [4];
  always @(posedge clk or negedge rst_n) begin
    bit acc;
    int b;
    if (!rst_n) begin
      m_full = 0; m_sel = 0; m_ptr = 0; m_word = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      acc = m_full && out_ready[m_sel];
      if (acc) begin
        m_ptr = (m_sel + 1) % 4;
        if (m_cnt[m_sel] < 255) m_cnt[m_sel]++;
      end
      if (in_valid && (!m_full || acc)) begin
        b = m_full ? (m_sel + 1) % 4 : m_ptr;
        m_sel = b;
        for (int i = 3; i >= 0; i--) if (out_ready[(b + i) % 4]) m_sel = (b + i) % 4;
        m_word = in_data;
        m_full = 1;
      end else if (acc) m_full = 0;
    end
  end

  // compare DUT against the model mid-cycle
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_full ? (1 << m_sel) : 0);
    chk("busy", busy, m_full);
    chk("sel", sel, m_sel);
    chk("in_ready", in_ready, (!m_full || out_ready[m_sel]) ? 1 : 0);
    if (m_full) chk("out_data", out_data, m_word);
`ifdef DISPATCH_STATS_EN
    for (int k = 0; k < 4; k++) chk("cnt", cnt_flat[k*CNT_W +: CNT_W], m_cnt[k]);
`endif
  end

  task automatic do_reset();
    in_valid = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    logic [3:0] exp_ov [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit f;
    // 1: back-to-back words, all channels ready
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    out_ready = 4'b1111; in_valid = 1; in_data = 16'h0001;
    @(negedge clk) chk("t1_in_ready0", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_data = 16'(i + 2);
      in_valid = (i < 4);
      @(negedge clk);
      chk("t1_out_valid", out_valid, exp_ov[i]);
      chk("t1_sel", sel, i % 4);
      chk("t1_out_data", out_data, i + 1);
      chk("t1_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    // 2: only channel 2 ready
    do_reset();
    out_ready = 4'b0100; in_valid = 1; in_data = 16'hBEEF;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("t2_out_valid", out_valid, 4'b0100);
    chk("t2_sel", sel, 2);
    chk("t2_out_data", out_data, 16'hBEEF);
    @(posedge clk); #1;
    @(negedge clk) chk("t2_busy", busy, 0);
    out_ready = 4'b1111; in_valid = 1; in_data = 16'h0002;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk) chk("t2_ptr3", sel, 3);
    @(posedge clk); #1;
    // 3: nothing ready, word is held steady
    do_reset();
    out_ready = 4'b0000; in_valid = 1; in_data = 16'h1234;
    @(posedge clk); #1 in_valid = 0;
    repeat (5) @(negedge clk) begin
      chk("t3_out_valid", out_valid, 4'b0001);
      chk("t3_out_data", out_data, 16'h1234);
      chk("t3_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 4'b0001;
    @(negedge clk) chk("t3_in_ready_acc", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk) chk("t3_busy", busy, 0);
    // 4: async reset while offering
    do_reset();
    out_ready = 4'b0010; in_valid = 1; in_data = 16'h00AA;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1 out_ready = 4'b0000; in_valid = 1; in_data = 16'h00BB;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk) chk("t4_held_sel", sel, 2);
    #2 rst_n = 0;
    #1;
    chk("t4_rst_out_valid", out_valid, 0);
    chk("t4_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    out_ready = 4'b1111; in_valid = 1; in_data = 16'h00CC;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk) chk("t4_sel_after", sel, 0);
    @(posedge clk); #1;
    // 6: coincident accept and capture wrapping 3 -> 0
    do_reset();
    out_ready = 4'b1000; in_valid = 1; in_data = 16'h000A;
    @(posedge clk); #1 in_data = 16'h000B; out_ready = 4'b1001;
    @(negedge clk);
    chk("t6_sel3", sel, 3);
    chk("t6_ov3", out_valid, 4'b1000);
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("t6_sel0", sel, 0);
    chk("t6_ov0", out_valid, 4'b0001);
    chk("t6_data", out_data, 16'h000B);
    @(posedge clk); #1;
`ifdef DISPATCH_STATS_EN
    // 5: saturation on channel 1
    do_reset();
    out_ready = 4'b0010; in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      in_data = 16'(i);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_cnt0", cnt_flat[0 +: CNT_W], 0);
    chk("t5_cnt1", cnt_flat[CNT_W +: CNT_W], 255);
    chk("t5_cnt2", cnt_flat[2*CNT_W +: CNT_W], 0);
    chk("t5_cnt3", cnt_flat[3*CNT_W +: CNT_W], 0);
`endif
    // random traffic obeying valid/ready
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk) f = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || f) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      if (c == 1500) do_reset();
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
